// File: rtl/sdram_traffic_pkg.sv
// Shared encodings and the data-pattern function for the SDRAM traffic generator.
//   state_e      : engine FSM states
//   MODE_*       : runtime mode select values
//   PAT_*        : data pattern select values
//   pattern_data : address + pattern select -> data (up to 64-bit address/data)
package sdram_traffic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain
  } state_e;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_READ   = 2'd1;
  localparam logic [1:0] MODE_WRITE  = 2'd2;
  localparam logic [1:0] MODE_VERIFY = 2'd3;

  localparam logic [2:0] PAT_HASH  = 3'd0;
  localparam logic [2:0] PAT_ADDR  = 3'd1;
  localparam logic [2:0] PAT_ONES  = 3'd2;
  localparam logic [2:0] PAT_ZEROS = 3'd3;
  localparam logic [2:0] PAT_CONST = 3'd4;

  // Hash: {7'h55, addr[aw-1:dw]} ^ ~addr[dw-1:0]. With aw=25, dw=16 this is
  // {7'h55, addr[24:16]} ^ ~addr[15:0]. Result is masked to dw bits.
  function automatic logic [63:0] pattern_data(input logic [2:0]   pat,
                                               input logic [63:0]  addr,
                                               input int unsigned  aw,
                                               input int unsigned  dw,
                                               input logic [63:0]  const_pat);
    logic [63:0] amask;
    logic [63:0] dmask;
    logic [63:0] a;
    logic [63:0] hi;
    logic [63:0] res;
    amask = (aw >= 64) ? '1 : ((64'd1 << aw) - 64'd1);
    dmask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    a     = addr & amask;
    hi    = '0;
    if (aw > dw) hi = (64'h55 << (aw - dw)) | (a >> dw);
    case (pat)
      PAT_HASH:  res = hi ^ ~a;
      PAT_ADDR:  res = a;
      PAT_ONES:  res = '1;
      PAT_ZEROS: res = '0;
      PAT_CONST: res = const_pat;
      default:   res = '0;
    endcase
    return res & dmask;
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Combinational data-pattern generator.
//   addr    in  ADDR_WIDTH  address the data belongs to
//   pattern in  3           pattern select (PAT_*)
//   data    out DATA_WIDTH  pattern data for addr
module sdram_pattern_gen
  import sdram_traffic_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH    = 25,
  parameter int unsigned            DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0]  CONST_PATTERN = 16'h7832
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            pattern,
  output logic [DATA_WIDTH-1:0] data
);

  logic [63:0] full;

  always_comb begin
    full = pattern_data(pattern, 64'(addr), ADDR_WIDTH, DATA_WIDTH, 64'(CONST_PATTERN));
  end

  assign data = full[DATA_WIDTH-1:0];

  // Upper bits are always zero after masking.
  logic unused_hi;
  assign unused_hi = ^full;

endmodule

// File: rtl/sdram_traffic_gen.sv
// SDRAM traffic / verification engine for the controller command port.
//   clk, rst          : clock, synchronous active-high reset
//   start, stop       : run request (sampled when idle) and graceful stop request
//   mode, pattern, loop : run configuration, latched on an accepted start
//   busy, done        : engine active, 1-cycle pulse on return to idle
//   passCount         : completed verify passes (wraps)
//   errCount          : read mismatches (saturating); errSticky / firstErrAddr log the first one
//   cmd*              : controller command port; read data returns in issue order
module sdram_traffic_gen
  import sdram_traffic_pkg::*;
#(
  parameter int unsigned              ADDR_WIDTH     = 25,
  parameter int unsigned              DATA_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0]    ADDR_START     = '0,
  parameter logic [ADDR_WIDTH-1:0]    ADDR_END       = {ADDR_WIDTH{1'b1}},
  parameter int unsigned              ERR_CNT_WIDTH  = 16,
  parameter int unsigned              PASS_CNT_WIDTH = 16,
  parameter int unsigned              MAX_OUTSTAND   = 8,
  parameter logic [DATA_WIDTH-1:0]    CONST_PATTERN  = 16'h7832
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [1:0]                mode,
  input  logic [2:0]                pattern,
  input  logic                      loop,
  output logic                      busy,
  output logic                      done,
  output logic [PASS_CNT_WIDTH-1:0] passCount,
  output logic [ERR_CNT_WIDTH-1:0]  errCount,
  output logic                      errSticky,
  output logic [ADDR_WIDTH-1:0]     firstErrAddr,
  input  logic                      cmdReady,
  output logic                      cmdTrigger,
  output logic [ADDR_WIDTH-1:0]     cmdAddr,
  output logic                      cmdWrite,
  output logic [DATA_WIDTH-1:0]     cmdWriteData,
  input  logic [DATA_WIDTH-1:0]     cmdReadData,
  input  logic                      cmdReadDataValid
);

  localparam int unsigned OutW = $clog2(MAX_OUTSTAND + 1);

  state_e                    state_q, state_d;
  logic [1:0]                mode_q;
  logic [2:0]                pat_q;
  logic                      loop_q, stop_q, win_done_q, done_q;
  logic [ADDR_WIDTH-1:0]     addr_q, exp_addr_q, first_err_q;
  logic [OutW-1:0]           out_q;
  logic [PASS_CNT_WIDTH-1:0] pass_q;
  logic [ERR_CNT_WIDTH-1:0]  err_q;
  logic                      sticky_q;

  logic [DATA_WIDTH-1:0] wr_data, chk_data;
  logic trig, accept, read_acc, at_end, start_ok, stop_pend, rd_ret, mismatch;
  logic go_idle, restart, win_done_set;
  logic [ADDR_WIDTH-1:0] addr_next, exp_next;

  sdram_pattern_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .CONST_PATTERN(CONST_PATTERN)
  ) u_wr_pat (
    .addr   (addr_q),
    .pattern(pat_q),
    .data   (wr_data)
  );

  sdram_pattern_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .CONST_PATTERN(CONST_PATTERN)
  ) u_chk_pat (
    .addr   (exp_addr_q),
    .pattern(pat_q),
    .data   (chk_data)
  );

  always_comb begin
    trig      = (state_q == StWrite) ||
                ((state_q == StRead) && (out_q != OutW'(MAX_OUTSTAND)));
    accept    = trig && cmdReady;
    read_acc  = accept && (state_q == StRead);
    at_end    = (addr_q == ADDR_END);
    addr_next = at_end ? ADDR_START : addr_q + ADDR_WIDTH'(1);
    exp_next  = (exp_addr_q == ADDR_END) ? ADDR_START : exp_addr_q + ADDR_WIDTH'(1);
    start_ok  = start && (state_q == StIdle);
    stop_pend = stop_q || stop;
    // Returns with nothing outstanding belong to reads issued before a reset.
    rd_ret    = cmdReadDataValid && (out_q != '0);
    mismatch  = rd_ret && (mode_q == MODE_VERIFY) && (cmdReadData != chk_data);
  end

  always_comb begin
    state_d      = state_q;
    go_idle      = 1'b0;
    restart      = 1'b0;
    win_done_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (mode != MODE_IDLE)) state_d = (mode == MODE_READ) ? StRead : StWrite;
      end
      StWrite: begin
        if (accept) begin
          if (stop_pend)                            state_d = StDrain;
          else if ((mode_q == MODE_VERIFY) && at_end) state_d = StRead;
        end
      end
      StRead: begin
        if (accept) begin
          if ((mode_q == MODE_VERIFY) && at_end) begin
            state_d      = StDrain;
            win_done_set = 1'b1;
          end else if (stop_pend) begin
            state_d = StDrain;
          end
        end else if (!trig && stop_pend) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_q == '0) begin
          if (loop_q && win_done_q && !stop_pend) begin
            state_d = StWrite;
            restart = 1'b1;
          end else begin
            state_d = StIdle;
            go_idle = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= MODE_IDLE;
      pat_q       <= PAT_HASH;
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
      win_done_q  <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= ADDR_START;
      exp_addr_q  <= ADDR_START;
      first_err_q <= '0;
      out_q       <= '0;
      pass_q      <= '0;
      err_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (start_ok && (mode == MODE_IDLE)) || go_idle;

      if (start_ok)                          stop_q <= stop && (mode != MODE_IDLE);
      else if (go_idle)                      stop_q <= 1'b0;
      else if (stop && (state_q != StIdle))  stop_q <= 1'b1;

      if (win_done_set)                        win_done_q <= 1'b1;
      else if (restart || go_idle || start_ok) win_done_q <= 1'b0;

      if (read_acc && !rd_ret)      out_q <= out_q + OutW'(1);
      else if (!read_acc && rd_ret) out_q <= out_q - OutW'(1);

      if ((state_q == StDrain) && (out_q == '0) && win_done_q) begin
        pass_q <= pass_q + PASS_CNT_WIDTH'(1);
      end

      if (start_ok) begin
        mode_q      <= mode;
        pat_q       <= pattern;
        loop_q      <= loop;
        addr_q      <= ADDR_START;
        exp_addr_q  <= ADDR_START;
        pass_q      <= '0;
        err_q       <= '0;
        sticky_q    <= 1'b0;
        first_err_q <= '0;
      end else begin
        if (restart) begin
          addr_q     <= ADDR_START;
          exp_addr_q <= ADDR_START;
        end else begin
          if (accept) addr_q     <= addr_next;
          if (rd_ret) exp_addr_q <= exp_next;
        end
        if (mismatch) begin
          if (err_q != '1) err_q <= err_q + ERR_CNT_WIDTH'(1);
          if (!sticky_q) begin
            sticky_q    <= 1'b1;
            first_err_q <= exp_addr_q;
          end
        end
      end
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign passCount    = pass_q;
  assign errCount     = err_q;
  assign errSticky    = sticky_q;
  assign firstErrAddr = first_err_q;
  assign cmdTrigger   = trig;
  assign cmdAddr      = addr_q;
  assign cmdWrite     = (state_q == StWrite);
  assign cmdWriteData = (state_q == StWrite) ? wr_data : '0;

endmodule
